// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types for the data-memory port arbiter.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MASK_W = 2;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [MASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_BUSY = 2'd1,
    LD_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ST   = 2'd1,
    GNT_LD   = 2'd2
  } arb_grant_t;

  // Control half of the memory bus; write data is kept separate since its width is a parameter.
  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      addr;
    lc3b_mem_wmask byte_en;
  } mem_ctl_t;

  // Stores win unless a starved load is due; flush only ever blocks the load side.
  function automatic arb_grant_t arb_pick(input logic st_req, input logic ld_req,
                                          input logic flush, input logic limit_hit);
    arb_grant_t g;
    g = GNT_NONE;
    if (st_req && (!ld_req || flush || !limit_hit)) begin
      g = GNT_ST;
    end else if (ld_req && !flush) begin
      g = GNT_LD;
    end
    return g;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of store grants taken while a load waits; built only with DMEM_ARB_FAIRNESS_EN.
`ifdef DMEM_ARB_FAIRNESS_EN
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic ld_req_i,
  input  logic st_grant_i,
  input  logic ld_grant_i,
  output logic at_limit_o
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_limit_q;

  always_comb begin
    count_d = count_q;
    if (ld_grant_i || (idle_i && !ld_req_i)) begin
      count_d = '0;
    end else if (st_grant_i && ld_req_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Flag is registered alongside the count so the arbiter sees a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      at_limit_q <= 1'(STARVE_LIMIT == 0);
    end else begin
      count_q    <= count_d;
      at_limit_q <= (count_d == LIMIT);
    end
  end

  assign at_limit_o = at_limit_q;

endmodule
`endif

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between committed stores and buffered loads.
// Optional load-starvation fairness is enabled with DMEM_ARB_FAIRNESS_EN.
module dmem_port_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned data_width   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_req,
  input  lc3b_word              st_addr,
  input  logic [data_width-1:0] st_wdata,
  input  lc3b_mem_wmask         st_byte_en,
  output logic                  st_ack,
  input  logic                  ld_req,
  input  lc3b_word              ld_addr,
  output logic                  ld_ack,
  output logic [data_width-1:0] ld_rdata,
  input  logic                  flush,
  output logic                  mem_read,
  output logic                  mem_write,
  output lc3b_word              mem_address,
  output logic [data_width-1:0] mem_wdata,
  output lc3b_mem_wmask         mem_byte_enable,
  input  logic                  mem_resp,
  input  logic [data_width-1:0] mem_rdata
);

  arb_state_t            state_q, state_d;
  mem_ctl_t              ctl_q, ctl_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic                  kill_q, kill_d;
  logic                  kill_c;
  logic                  limit_hit_c;
  arb_grant_t            grant_c;

  // A flush arriving on the response cycle must still squash that response.
  assign kill_c = kill_q | (flush & (state_q == LD_BUSY));

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    wdata_d = wdata_q;
    kill_d  = kill_q;
    grant_c = GNT_NONE;
    unique case (state_q)
      IDLE: begin
        kill_d  = 1'b0;
        grant_c = arb_pick(st_req, ld_req, flush, limit_hit_c);
        if (grant_c == GNT_ST) begin
          state_d = ST_BUSY;
          ctl_d   = '{read: 1'b0, write: 1'b1, addr: st_addr, byte_en: st_byte_en};
          wdata_d = st_wdata;
        end else if (grant_c == GNT_LD) begin
          state_d = LD_BUSY;
          ctl_d   = '{read: 1'b1, write: 1'b0, addr: ld_addr, byte_en: '0};
          wdata_d = '0;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          state_d     = IDLE;
          ctl_d.write = 1'b0;
        end
      end
      LD_BUSY: begin
        kill_d = kill_c;
        if (mem_resp) begin
          state_d    = IDLE;
          ctl_d.read = 1'b0;
          kill_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ctl_d   = '0;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      wdata_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      wdata_q <= wdata_d;
      kill_q  <= kill_d;
    end
  end

`ifdef DMEM_ARB_FAIRNESS_EN
  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle_i    (state_q == IDLE),
    .ld_req_i  (ld_req),
    .st_grant_i(grant_c == GNT_ST),
    .ld_grant_i(grant_c == GNT_LD),
    .at_limit_o(limit_hit_c)
  );
`else
  // Without fairness stores always win and the limit has no effect.
  logic unused_starve_limit;
  assign unused_starve_limit = |32'(STARVE_LIMIT);
  assign limit_hit_c         = 1'b0;
`endif

  assign mem_read        = ctl_q.read;
  assign mem_write       = ctl_q.write;
  assign mem_address     = ctl_q.addr;
  assign mem_byte_enable = ctl_q.byte_en;
  assign mem_wdata       = wdata_q;

  assign st_ack   = mem_resp & (state_q == ST_BUSY);
  assign ld_ack   = mem_resp & (state_q == LD_BUSY) & ~kill_c;
  assign ld_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter; fairness expectations follow DMEM_ARB_FAIRNESS_EN.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_req, ld_req, flush, mem_resp;
  logic [15:0] st_addr, st_wdata, ld_addr, mem_rdata;
  logic [1:0]  st_byte_en;
  logic        st_ack, ld_ack, mem_read, mem_write;
  logic [15:0] ld_rdata, mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.data_width(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_byte_en(st_byte_en),
    .st_ack(st_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st; logic [15:0] sa; logic [15:0] sw; logic [1:0] sb;
    logic        ld; logic [15:0] la;
    logic        fl; logic rs; logic [15:0] rd;
    logic        e_mw; logic e_mr; logic [15:0] e_a; logic [15:0] e_wd; logic [1:0] e_be;
    logic        e_sa; logic e_la;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic st, logic [15:0] sa, logic [15:0] sw, logic [1:0] sb,
                             logic ld, logic [15:0] la, logic fl, logic rs, logic [15:0] rd,
                             logic e_mw, logic e_mr, logic [15:0] e_a, logic [15:0] e_wd,
                             logic [1:0] e_be, logic e_sa, logic e_la);
    vec_t r;
    r.st = st; r.sa = sa; r.sw = sw; r.sb = sb; r.ld = ld; r.la = la;
    r.fl = fl; r.rs = rs; r.rd = rd;
    r.e_mw = e_mw; r.e_mr = e_mr; r.e_a = e_a; r.e_wd = e_wd; r.e_be = e_be;
    r.e_sa = e_sa; r.e_la = e_la;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    st_req = 1'b0; ld_req = 1'b0; flush = 1'b0; mem_resp = 1'b0;
    st_addr = '0; st_wdata = '0; st_byte_en = '0; ld_addr = '0; mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int kinds[$];
    int exp_kind;
    int cyc;

    // Store, load, flush and bubble scenarios, one row per clock.
    tbl.push_back(v(1,16'h1000,16'hBEEF,2'b11, 0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h1000,16'hBEEF,2'b11, 0,16'h0, 0,0,16'h0,    1,0,16'h1000,16'hBEEF,2'b11, 0,0));
    tbl.push_back(v(1,16'h1000,16'hBEEF,2'b11, 0,16'h0, 0,0,16'h0,    1,0,16'h1000,16'hBEEF,2'b11, 0,0));
    tbl.push_back(v(1,16'h1000,16'hBEEF,2'b11, 0,16'h0, 0,1,16'h0,    1,0,16'h1000,16'hBEEF,2'b11, 1,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h2002, 0,0,16'h0, 0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h2002, 0,0,16'h0, 0,1,16'h2002,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h2002, 0,1,16'h1234, 0,1,16'h2002,16'h0,2'b00, 0,1));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h3000,16'h1111,2'b01, 1,16'h4000, 1,0,16'h0, 0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h3000,16'h1111,2'b01, 1,16'h4000, 0,0,16'h0, 1,0,16'h3000,16'h1111,2'b01, 0,0));
    tbl.push_back(v(1,16'h3000,16'h1111,2'b01, 1,16'h4000, 0,1,16'h0, 1,0,16'h3000,16'h1111,2'b01, 1,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h4000, 0,0,16'h0, 0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h4000, 1,0,16'h0, 0,1,16'h4000,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,1,16'h4000,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,1,16'hDEAD, 0,1,16'h4000,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,1,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h5000, 0,0,16'h0, 0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h5000, 0,0,16'h0, 0,1,16'h5000,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h5000, 1,1,16'h7777, 0,1,16'h5000,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h6000, 0,0,16'h0, 0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       1,16'h6000, 0,1,16'hABCD, 0,1,16'h6000,16'h0,2'b00, 0,1));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h7000,16'h5555,2'b10, 0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h7000,16'h5555,2'b10, 0,16'h0, 1,0,16'h0,    1,0,16'h7000,16'h5555,2'b10, 0,0));
    tbl.push_back(v(1,16'h7000,16'h5555,2'b10, 0,16'h0, 1,1,16'h0,    1,0,16'h7000,16'h5555,2'b10, 1,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h8000,16'h0001,2'b11, 0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h8000,16'h0001,2'b11, 0,16'h0, 0,1,16'h0,    1,0,16'h8000,16'h0001,2'b11, 1,0));
    tbl.push_back(v(1,16'h8002,16'h0002,2'b01, 0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));
    tbl.push_back(v(1,16'h8002,16'h0002,2'b01, 0,16'h0, 0,1,16'h0,    1,0,16'h8002,16'h0002,2'b01, 1,0));
    tbl.push_back(v(0,16'h0,16'h0,2'b00,       0,16'h0, 0,0,16'h0,    0,0,16'h0,16'h0,2'b00, 0,0));

    // Power-on reset: everything quiet.
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_byte_enable", mem_byte_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      st_req = tbl[i].st; st_addr = tbl[i].sa; st_wdata = tbl[i].sw; st_byte_en = tbl[i].sb;
      ld_req = tbl[i].ld; ld_addr = tbl[i].la; flush = tbl[i].fl;
      mem_resp = tbl[i].rs; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("row%0d_mem_write", i), mem_write, tbl[i].e_mw);
      chk($sformatf("row%0d_mem_read", i), mem_read, tbl[i].e_mr);
      chk($sformatf("row%0d_st_ack", i), st_ack, tbl[i].e_sa);
      chk($sformatf("row%0d_ld_ack", i), ld_ack, tbl[i].e_la);
      chk($sformatf("row%0d_ld_rdata", i), ld_rdata, tbl[i].rd);
      if (tbl[i].e_mw || tbl[i].e_mr)
        chk($sformatf("row%0d_mem_address", i), mem_address, tbl[i].e_a);
      if (tbl[i].e_mw) begin
        chk($sformatf("row%0d_mem_wdata", i), mem_wdata, tbl[i].e_wd);
        chk($sformatf("row%0d_mem_byte_enable", i), mem_byte_enable, tbl[i].e_be);
      end
    end

    // Continuous stores against a pending load: record who wins each transaction.
    @(negedge clk);
    idle_inputs();
    st_req = 1'b1; st_addr = 16'hA000; st_wdata = 16'h0F0F; st_byte_en = 2'b11;
    ld_req = 1'b1; ld_addr = 16'hB000;
    cyc = 0;
    while (kinds.size() < 6 && cyc < 200) begin
      @(negedge clk);
      mem_resp = mem_write | mem_read;
      if (mem_resp) kinds.push_back(mem_read ? 1 : 0);
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    if (kinds.size() < 6) chk("starve_timeout_grants", kinds.size(), 6);
    foreach (kinds[i]) begin
`ifdef DMEM_ARB_FAIRNESS_EN
      exp_kind = (i == 4) ? 1 : 0;
`else
      exp_kind = 0;
`endif
      chk($sformatf("starve_grant%0d_is_load", i), kinds[i], exp_kind);
    end

    // Reset in the middle of a store, then a stale response afterwards.
    @(negedge clk);
    st_req = 1'b1; st_addr = 16'h9000; st_wdata = 16'h4321; st_byte_en = 2'b11;
    @(negedge clk);
    #1;
    chk("midrst_pre_mem_write", mem_write, 1);
    chk("midrst_pre_mem_address", mem_address, 16'h9000);
    rst_n = 1'b0;
    st_req = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("midrst_mem_write", mem_write, 0);
    chk("midrst_mem_address", mem_address, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_mem_byte_enable", mem_byte_enable, 0);
    chk("midrst_st_ack", st_ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("stale_resp_st_ack", st_ack, 0);
    chk("stale_resp_ld_ack", ld_ack, 0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("post_rst_mem_write", mem_write, 0);
    chk("post_rst_mem_read", mem_read, 0);
    @(negedge clk);
    #1;
    chk("post_rst_idle_mem_write", mem_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
